// File: rtl/com_pkg.sv
// Shared types and constants for the complex-add arbiter slice.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package com_pkg;

    // Job sequencer states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    // EFP operand layout: sign | exponent | mantissa (mantissa takes the rest)
    localparam int EFP_SIGN_W = 1;
    localparam int EFP_EXP_W  = 6;

    // Default abort limit for a running job, in RUN cycles
    localparam int TIMEOUT_DEF = 15;

    // Requester index width (up to 8 requesters) and RUN counter width (limit up to 255)
    localparam int ID_W  = 3;
    localparam int CNT_W = 8;

    // Mantissa width for a given EFP operand width
    function automatic int efp_mant_w(input int width);
        return width - EFP_SIGN_W - EFP_EXP_W;
    endfunction

endpackage

// File: rtl/com_add_arbiter_rr_pick.sv
// Round-robin priority picker: first requester after last_winner, wrapping mod NREQ.
// Latency: purely combinational.
// Backpressure: none; winner_vld is low when no request bit is set.
module rr_pick
    import com_pkg::*;
#(
    parameter int NREQ = 4
)(
    input  logic [NREQ-1:0] req,
    input  logic [ID_W-1:0] last_winner,
    output logic [ID_W-1:0] winner,
    output logic            winner_vld
);

    logic [7:0] req_ext;
    logic [3:0] cand;

    assign req_ext = 8'(req);

    // Scan farthest-to-nearest so the requester closest after last_winner overrides the rest
    always_comb begin
        winner     = '0;
        winner_vld = 1'b0;
        cand       = '0;
        for (int off = NREQ; off >= 1; off--) begin
            cand = {1'b0, last_winner} + 4'(off);
            if (cand >= 4'(NREQ)) begin
                cand = cand - 4'(NREQ);
            end
            if (req_ext[cand[2:0]]) begin
                winner     = cand[2:0];
                winner_vld = 1'b1;
            end
        end
    end

endmodule

// File: rtl/com_add_arbiter.sv
// Arbitrates NREQ requesters onto one external complex adder, one job at a time.
// Latency: IDLE->LOAD (grant) 1 cycle, RUN until add_over or TIMEOUT cycles, DONE 1 cycle.
// Backpressure: requesters hold req until their gnt pulse; no new job until the current one reaches DONE.
module com_add_arbiter
    import com_pkg::*;
#(
    parameter int WIDTH   = 16,
    parameter int NREQ    = 4,
    parameter int TIMEOUT = TIMEOUT_DEF
)(
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*WIDTH-1:0] req_a_re,
    input  logic [NREQ*WIDTH-1:0] req_a_im,
    input  logic [NREQ*WIDTH-1:0] req_b_re,
    input  logic [NREQ*WIDTH-1:0] req_b_im,
    output logic [NREQ-1:0]       gnt,
    output logic                  resp_valid,
    output logic [2:0]            resp_id,
    output logic [WIDTH-1:0]      resp_re,
    output logic [WIDTH-1:0]      resp_im,
    output logic                  resp_err,
    output logic                  busy,
    output logic                  add_flag,
    output logic [WIDTH-1:0]      add_a_re,
    output logic [WIDTH-1:0]      add_a_im,
    output logic [WIDTH-1:0]      add_b_re,
    output logic [WIDTH-1:0]      add_b_im,
    input  logic                  add_over,
    input  logic [WIDTH-1:0]      add_res_re,
    input  logic [WIDTH-1:0]      add_res_im
);

    state_t           state;
    state_t           state_nx;
    logic [ID_W-1:0]  last_winner;
    logic [ID_W-1:0]  winner_q;
    logic [ID_W-1:0]  pick_idx;
    logic             pick_vld;
    logic [CNT_W-1:0] run_cnt;
    logic [CNT_W-1:0] run_cnt_inc;
    logic             timeout_hit;
    logic [WIDTH-1:0] sel_a_re;
    logic [WIDTH-1:0] sel_a_im;
    logic [WIDTH-1:0] sel_b_re;
    logic [WIDTH-1:0] sel_b_im;

    rr_pick #(
        .NREQ(NREQ)
    ) u_rr_pick (
        .req        (req),
        .last_winner(last_winner),
        .winner     (pick_idx),
        .winner_vld (pick_vld)
    );

    // The cycle that would bring the count to TIMEOUT is the last RUN cycle allowed
    assign run_cnt_inc = run_cnt + CNT_W'(1);
    assign timeout_hit = (run_cnt_inc == CNT_W'(TIMEOUT));

    // State register; reset drops any job in flight
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state: completion beats timeout when both land on the same cycle
    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE: if (pick_vld) state_nx = ST_LOAD;
            ST_LOAD: state_nx = ST_RUN;
            ST_RUN:  if (add_over || timeout_hit) state_nx = ST_DONE;
            ST_DONE: state_nx = ST_IDLE;
            default: state_nx = ST_IDLE;
        endcase
    end

    // State-decoded outputs; add_flag only in RUN so the adder sees a low gap between jobs
    always_comb begin
        gnt        = '0;
        add_flag   = 1'b0;
        busy       = 1'b1;
        resp_valid = 1'b0;
        case (state)
            ST_IDLE: busy = 1'b0;
            ST_LOAD: gnt = {{(NREQ-1){1'b0}}, 1'b1} << winner_q;
            ST_RUN:  add_flag = 1'b1;
            ST_DONE: resp_valid = 1'b1;
            default: busy = 1'b0;
        endcase
    end

    // Operand mux for the registered winner
    always_comb begin
        sel_a_re = '0;
        sel_a_im = '0;
        sel_b_re = '0;
        sel_b_im = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (winner_q == ID_W'(i)) begin
                sel_a_re = req_a_re[i*WIDTH +: WIDTH];
                sel_a_im = req_a_im[i*WIDTH +: WIDTH];
                sel_b_re = req_b_re[i*WIDTH +: WIDTH];
                sel_b_im = req_b_im[i*WIDTH +: WIDTH];
            end
        end
    end

    // Job datapath: winner latch, operand capture on the grant cycle, RUN counter, response capture
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_winner <= ID_W'(NREQ - 1);
            winner_q    <= '0;
            run_cnt     <= '0;
            add_a_re    <= '0;
            add_a_im    <= '0;
            add_b_re    <= '0;
            add_b_im    <= '0;
            resp_id     <= '0;
            resp_re     <= '0;
            resp_im     <= '0;
            resp_err    <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (pick_vld) begin
                        winner_q <= pick_idx;
                    end
                end
                ST_LOAD: begin
                    add_a_re    <= sel_a_re;
                    add_a_im    <= sel_a_im;
                    add_b_re    <= sel_b_re;
                    add_b_im    <= sel_b_im;
                    last_winner <= winner_q;
                    run_cnt     <= '0;
                end
                ST_RUN: begin
                    run_cnt <= run_cnt_inc;
                    if (add_over) begin
                        resp_re  <= add_res_re;
                        resp_im  <= add_res_im;
                        resp_err <= 1'b0;
                        resp_id  <= winner_q;
                    end else if (timeout_hit) begin
                        resp_re  <= '0;
                        resp_im  <= '0;
                        resp_err <= 1'b1;
                        resp_id  <= winner_q;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_com_add_arbiter.sv
// Bench for com_add_arbiter: directed vector table for single jobs plus sequences
// for round-robin order, mid-job reset and a request withdrawn during another grant.
// Outputs are sampled on the falling edge; inputs change 1 time unit after the rising edge.
module tb_com_add_arbiter;

    localparam int W = 16;
    localparam int N = 4;

    logic           clk;
    logic           rst;
    logic [N-1:0]   req;
    logic [N*W-1:0] req_a_re, req_a_im, req_b_re, req_b_im;
    logic [N-1:0]   gnt;
    logic           resp_valid;
    logic [2:0]     resp_id;
    logic [W-1:0]   resp_re, resp_im;
    logic           resp_err, busy, add_flag;
    logic [W-1:0]   add_a_re, add_a_im, add_b_re, add_b_im;
    logic           add_over;
    logic [W-1:0]   add_res_re, add_res_im;

    com_add_arbiter #(.WIDTH(W), .NREQ(N), .TIMEOUT(15)) dut (
        .clk(clk), .rst(rst), .req(req),
        .req_a_re(req_a_re), .req_a_im(req_a_im), .req_b_re(req_b_re), .req_b_im(req_b_im),
        .gnt(gnt), .resp_valid(resp_valid), .resp_id(resp_id),
        .resp_re(resp_re), .resp_im(resp_im), .resp_err(resp_err), .busy(busy),
        .add_flag(add_flag), .add_a_re(add_a_re), .add_a_im(add_a_im),
        .add_b_re(add_b_re), .add_b_im(add_b_im), .add_over(add_over),
        .add_res_re(add_res_re), .add_res_im(add_res_im)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stand-in adder: raises over on the lat-th consecutive flag cycle (lat=0: never);
    // the result is a plain integer sum so the pass-through is easy to predict.
    int lat;
    int fcnt;
    always @(posedge clk or posedge rst) begin
        if (rst) fcnt <= 0;
        else     fcnt <= add_flag ? fcnt + 1 : 0;
    end
    assign add_over   = add_flag && (lat != 0) && (fcnt == lat - 1);
    assign add_res_re = add_over ? add_a_re + add_b_re : 16'hDEAD;
    assign add_res_im = add_over ? add_a_im + add_b_im : 16'hDEAD;

    int n_chk = 0;
    int n_err = 0;
    logic auto_drop;

    logic [N-1:0] obs_gnt;
    logic         obs_rv, obs_err, obs_busy, obs_flag;
    logic [2:0]   obs_id;
    logic [W-1:0] obs_re, obs_im, obs_a_re, obs_a_im, obs_b_re, obs_b_im;
    logic [3:0]   exp_g [5];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Sample the current cycle, then move to just after the next rising edge;
    // a well-behaved requester lowers its req once it has seen its grant.
    task automatic tick();
        @(negedge clk);
        obs_gnt  = gnt;      obs_rv   = resp_valid; obs_id   = resp_id;
        obs_re   = resp_re;  obs_im   = resp_im;    obs_err  = resp_err;
        obs_busy = busy;     obs_flag = add_flag;
        obs_a_re = add_a_re; obs_a_im = add_a_im;   obs_b_re = add_b_re; obs_b_im = add_b_im;
        @(posedge clk);
        #1;
        if (auto_drop) req = req & ~obs_gnt;
    endtask

    function automatic int oh2idx(input logic [3:0] oh);
        for (int i = 0; i < 4; i++) if (oh[i]) return i;
        return 7;
    endfunction

    task automatic fill_junk();
        for (int i = 0; i < N; i++) begin
            req_a_re[i*W +: W] = 16'hA000 | 16'(i);
            req_a_im[i*W +: W] = 16'hA100 | 16'(i);
            req_b_re[i*W +: W] = 16'hB000 | 16'(i);
            req_b_im[i*W +: W] = 16'hB100 | 16'(i);
        end
    endtask

    // Called from IDLE with req just set: grants must follow exp_g[0..n-1], the first one
    // in the following cycle, and each response must belong to the latest grant.
    task automatic expect_order(input int n, input string tag);
        int ng = 0;
        int nr = 0;
        for (int k = 0; k < 120 && nr < n; k++) begin
            tick();
            if (obs_gnt != 0) begin
                if (ng == 0) chk({tag, "_first_gnt_cycle"}, k, 1);
                if (ng < n) chk({tag, "_gnt"}, 32'(obs_gnt), 32'(exp_g[ng]));
                else        chk({tag, "_extra_gnt"}, 32'(obs_gnt), 0);
                ng++;
            end
            if (obs_rv) begin
                chk({tag, "_resp_follows_gnt"}, nr + 1, ng);
                chk({tag, "_resp_id"}, 32'(obs_id), oh2idx(exp_g[nr]));
                chk({tag, "_resp_err"}, 32'(obs_err), 0);
                nr++;
            end
        end
        chk({tag, "_resp_count"}, nr, n);
        chk({tag, "_gnt_count"}, ng, n);
    endtask

    typedef struct {
        logic [3:0]  req;
        int          lat;
        logic [15:0] a_re, a_im, b_re, b_im;
        logic [3:0]  gnt;
        int          id;
        logic [15:0] re, im;
        logic        err;
        int          run;
    } vec_t;

    vec_t vt [7];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        //            req      lat a_re      a_im      b_re      b_im      gnt      id re        im        err  run
        vt[0] = '{4'b0010,  5, 16'h3C00, 16'h0000, 16'h3C00, 16'h0000, 4'b0010, 1, 16'h7800, 16'h0000, 1'b0,  5};
        vt[1] = '{4'b0100,  3, 16'h1234, 16'h0011, 16'h0101, 16'h0022, 4'b0100, 2, 16'h1335, 16'h0033, 1'b0,  3};
        vt[2] = '{4'b1000,  0, 16'h4000, 16'h4000, 16'h4000, 16'h4000, 4'b1000, 3, 16'h0000, 16'h0000, 1'b1, 15};
        vt[3] = '{4'b0001,  1, 16'h0000, 16'h0000, 16'h5555, 16'h00AA, 4'b0001, 0, 16'h5555, 16'h00AA, 1'b0,  1};
        vt[4] = '{4'b0001, 15, 16'h0001, 16'h0002, 16'h0003, 16'h0004, 4'b0001, 0, 16'h0004, 16'h0006, 1'b0, 15};
        vt[5] = '{4'b0100, 16, 16'hFFFF, 16'h8000, 16'h0001, 16'h8000, 4'b0100, 2, 16'h0000, 16'h0000, 1'b1, 15};
        vt[6] = '{4'b1000, 14, 16'h7FFF, 16'h0100, 16'h0001, 16'h0200, 4'b1000, 3, 16'h8000, 16'h0300, 1'b0, 14};

        rst = 1'b1; req = 4'b1111; lat = 2; auto_drop = 1'b0;
        fill_junk();

        // Reset state, with every requester asking
        tick(); tick();
        chk("rst_gnt", 32'(obs_gnt), 0);        chk("rst_resp_valid", 32'(obs_rv), 0);
        chk("rst_resp_err", 32'(obs_err), 0);   chk("rst_resp_id", 32'(obs_id), 0);
        chk("rst_resp_re", 32'(obs_re), 0);     chk("rst_resp_im", 32'(obs_im), 0);
        chk("rst_busy", 32'(obs_busy), 0);      chk("rst_add_flag", 32'(obs_flag), 0);
        chk("rst_add_a_re", 32'(obs_a_re), 0);  chk("rst_add_a_im", 32'(obs_a_im), 0);
        chk("rst_add_b_re", 32'(obs_b_re), 0);  chk("rst_add_b_im", 32'(obs_b_im), 0);

        // All requests held high from reset release: 0,1,2,3,0
        rst = 1'b0;
        exp_g[0] = 4'b0001; exp_g[1] = 4'b0010; exp_g[2] = 4'b0100;
        exp_g[3] = 4'b1000; exp_g[4] = 4'b0001;
        expect_order(5, "rr");
        req = 4'b0000;
        auto_drop = 1'b1;

        // Single-job vectors: grant in cycle 1, RUN from cycle 2, response in cycle run+2
        for (int v = 0; v < 7; v++) begin
            int g_cyc, r_cyc, nflag;
            logic [3:0] g_val;
            logic [2:0] r_id;
            logic [15:0] r_re, r_im, o_ar, o_ai, o_br, o_bi;
            logic r_err;
            for (int g = 0; g < 50 && busy; g++) tick();
            fill_junk();
            req_a_re[vt[v].id*W +: W] = vt[v].a_re;
            req_a_im[vt[v].id*W +: W] = vt[v].a_im;
            req_b_re[vt[v].id*W +: W] = vt[v].b_re;
            req_b_im[vt[v].id*W +: W] = vt[v].b_im;
            lat = vt[v].lat;
            req = vt[v].req;
            g_cyc = -1; r_cyc = -1; nflag = 0; g_val = '0;
            r_id = '0; r_re = '0; r_im = '0; r_err = 1'b0;
            o_ar = '0; o_ai = '0; o_br = '0; o_bi = '0;
            for (int k = 0; k < 40 && r_cyc < 0; k++) begin
                tick();
                if (obs_gnt != 0 && g_cyc < 0) begin g_cyc = k; g_val = obs_gnt; end
                if (obs_flag) nflag++;
                if (k == 2) begin o_ar = obs_a_re; o_ai = obs_a_im; o_br = obs_b_re; o_bi = obs_b_im; end
                if (obs_rv) begin r_cyc = k; r_id = obs_id; r_re = obs_re; r_im = obs_im; r_err = obs_err; end
            end
            chk($sformatf("v%0d_gnt", v), 32'(g_val), 32'(vt[v].gnt));
            chk($sformatf("v%0d_gnt_cycle", v), g_cyc, 1);
            chk($sformatf("v%0d_add_a_re", v), 32'(o_ar), 32'(vt[v].a_re));
            chk($sformatf("v%0d_add_a_im", v), 32'(o_ai), 32'(vt[v].a_im));
            chk($sformatf("v%0d_add_b_re", v), 32'(o_br), 32'(vt[v].b_re));
            chk($sformatf("v%0d_add_b_im", v), 32'(o_bi), 32'(vt[v].b_im));
            chk($sformatf("v%0d_flag_cycles", v), nflag, vt[v].run);
            chk($sformatf("v%0d_resp_cycle", v), r_cyc, vt[v].run + 2);
            chk($sformatf("v%0d_resp_id", v), 32'(r_id), vt[v].id);
            chk($sformatf("v%0d_resp_re", v), 32'(r_re), 32'(vt[v].re));
            chk($sformatf("v%0d_resp_im", v), 32'(r_im), 32'(vt[v].im));
            chk($sformatf("v%0d_resp_err", v), 32'(r_err), 32'(vt[v].err));
        end

        // Reset during the third RUN cycle of a job for requester 2
        for (int g = 0; g < 50 && busy; g++) tick();
        lat = 0;
        req = 4'b0100;
        for (int k = 0; k < 4; k++) begin
            tick();
            if (k == 1) chk("mid_rst_gnt", 32'(obs_gnt), 32'(4'b0100));
        end
        chk("mid_rst_flag_before", 32'(add_flag), 1);
        rst = 1'b1;
        req = 4'b1011;
        #1;
        chk("mid_rst_flag_now", 32'(add_flag), 0);
        chk("mid_rst_busy_now", 32'(busy), 0);
        chk("mid_rst_resp_valid_now", 32'(resp_valid), 0);
        tick();
        chk("mid_rst_no_resp_a", 32'(obs_rv), 0);
        tick();
        chk("mid_rst_no_resp_b", 32'(obs_rv), 0);
        rst = 1'b0;
        lat = 2;
        exp_g[0] = 4'b0001; exp_g[1] = 4'b0010; exp_g[2] = 4'b1000;
        expect_order(3, "post_rst");

        // Requester 2 withdraws in the cycle requester 3 is granted
        exp_g[0] = 4'b0100;
        req = 4'b0100;
        expect_order(1, "prep_last2");
        req = 4'b1100;
        tick();
        req = req & 4'b1011;
        tick();
        chk("drop_gnt", 32'(obs_gnt), 32'(4'b1000));
        begin
            int nresp = 0;
            int nextra = 0;
            logic [2:0] rid = '0;
            for (int k = 0; k < 20; k++) begin
                tick();
                if (obs_gnt != 0) nextra++;
                if (obs_rv) begin nresp++; rid = obs_id; end
            end
            chk("drop_resp_count", nresp, 1);
            chk("drop_resp_id", 32'(rid), 3);
            chk("drop_extra_gnt", nextra, 0);
            chk("drop_idle_after", 32'(busy), 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
        $finish;
    end

endmodule
